matrix_frame_capture: RTL

MATRIX_FRAME_CAPTURE -- requirements
Module: matrix_frame_capture

---
 rtl/matrix_frame_capture_pkg.sv | 24 ++
 rtl/matrix_frame_capture_onehot8_decode.sv | 31 +++
 rtl/matrix_frame_capture.sv | 111 +++++++++++
 3 files changed

// File: rtl/matrix_frame_capture_pkg.sv
// Shared sizes, row classification and a popcount helper for the 8x8 scan-matrix frame capture.
package matrix_frame_capture_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;
    localparam int FRAME_BITS  = 64;
    localparam int BUF_BITS    = FRAME_BITS - MATRIX_COLS;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        ONEHOT = 2'd1,
        MULTI  = 2'd2
    } row_class_e;

    function automatic logic [3:0] pop8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/matrix_frame_capture_onehot8_decode.sv
// Combinational classifier for a row strobe: blank, single row (with its index) or multiple rows.
module onehot8_decode
    import matrix_frame_capture_pkg::*;
(
    input  logic [7:0]  i_row,
    output row_class_e  o_class,
    output logic [2:0]  o_idx
);

    logic [3:0] w_ones;

    // Count set bits, pick the highest set bit as index, then classify
    always_comb begin
        w_ones  = pop8(i_row);
        o_idx   = 3'd0;
        o_class = BLANK;
        for (int i = 0; i < 8; i++) begin
            if (i_row[i]) begin
                o_idx = 3'(i);
            end else begin
                o_idx = o_idx;
            end
        end
        case (w_ones)
            4'd0:    o_class = BLANK;
            4'd1:    o_class = ONEHOT;
            default: o_class = MULTI;
        endcase
    end

endmodule

// File: rtl/matrix_frame_capture.sv
// Captures one 8x8 frame from a row-scanned LED driver bus, with sequence checking and a
// single-entry hand-off register guarded by frame_valid/frame_ack.
module matrix_frame_capture
    import matrix_frame_capture_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             row,
    input  logic [7:0]             column,
    input  logic                   frame_ack,
    output logic [FRAME_BITS-1:0]  data,
    output logic                   frame_valid,
    output logic                   seq_err,
    output logic                   onehot_err,
    output logic                   overrun,
    output logic [7:0]             frame_count
);

    logic [7:0]            r_row_q;
    logic [7:0]            r_column_q;
    logic [2:0]            r_exp;
    logic [BUF_BITS-1:0]   r_buf;
    logic [FRAME_BITS-1:0] r_data;
    logic                  r_frame_valid;
    logic                  r_seq_err;
    logic                  r_onehot_err;
    logic                  r_overrun;
    logic [7:0]            r_frame_count;

    row_class_e            w_class;
    logic [2:0]            w_idx;
    logic                  w_complete;
    logic [5:0]            w_slot;

    onehot8_decode u_decode (
        .i_row   (r_row_q),
        .o_class (w_class),
        .o_idx   (w_idx)
    );

    assign w_complete = (w_class == ONEHOT) && (w_idx == 3'd7) && (r_exp == 3'd7);
    assign w_slot     = {w_idx, 3'b000};

    // Input stage, row sequencer, and frame hand-off register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row_q       <= 8'd0;
            r_column_q    <= 8'd0;
            r_exp         <= 3'd0;
            r_buf         <= '0;
            r_data        <= '0;
            r_frame_valid <= 1'b0;
            r_seq_err     <= 1'b0;
            r_onehot_err  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_row_q      <= row;
            r_column_q   <= column;
            r_seq_err    <= 1'b0;
            r_onehot_err <= 1'b0;
            r_overrun    <= 1'b0;

            case (w_class)
                BLANK: r_exp <= 3'd0;
                MULTI: begin
                    r_onehot_err <= 1'b1;
                    r_exp        <= 3'd0;
                end
                ONEHOT: begin
                    if (w_idx == r_exp) begin
                        // Row 7 goes straight into the candidate, never into the buffer
                        if (w_idx != 3'd7) begin
                            r_buf[w_slot +: 8] <= r_column_q;
                        end
                        r_exp <= r_exp + 3'd1;
                    end else begin
                        r_seq_err <= 1'b1;
                        if (w_idx == 3'd0) begin
                            r_buf[7:0] <= r_column_q;
                            r_exp      <= 3'd1;
                        end else begin
                            r_exp <= 3'd0;
                        end
                    end
                end
                default: r_exp <= 3'd0;
            endcase

            if (w_complete) begin
                if (!r_frame_valid || frame_ack) begin
                    r_data        <= {r_column_q, r_buf};
                    r_frame_valid <= 1'b1;
                    r_frame_count <= r_frame_count + 8'd1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (frame_ack && r_frame_valid) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign frame_valid = r_frame_valid;
    assign seq_err     = r_seq_err;
    assign onehot_err  = r_onehot_err;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule
